ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Receives scan codes from a PS/2 keyboard and produces the 32-bit `keyb_char` word that the CPU memory map returns on keyboard reads. The block filters the open-collector PS/2 clock and decodes 11-bit device-to-host frames. It folds the `E0` (extended) and `F0` (break) prefixes into flag bits, then holds the last complete key code until the next one arrives. It sits between the board's PS/2 pins and the CPU read-data path.

## Interface

Parameters:
- `FILTER_LEN`, default 8: consecutive `clk` samples the synchronized PS/2 clock must hold a new level before the filtered clock changes.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a filtered falling edge, mid-frame, before the frame is abandoned.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous.
- `keyb_char`  out  32  [7:0] scan code, [8] break, [9] extended, [31:10] zero.
- `new_key`  out  1  one-cycle pulse when `keyb_char` is updated.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation

- **Synchronizers:** `ps2_clk` and `ps2_data` each pass through two flip-flops.
- **Clock filter:** `ps2_clk_filt` changes only after the synchronized clock has differed from it for `FILTER_LEN` consecutive cycles. The filter counter clears on any sample equal to `ps2_clk_filt`. A fall event is the 1→0 transition of `ps2_clk_filt`.
- **Data sampling:** the synchronized data value is sampled on fall events only.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: fall event with data=0 (start bit) → DATA, bit count=0. Fall event with data=1 → stays in IDLE, no error.
  - DATA: each fall event shifts data in LSB first. After the 8th bit → PARITY.
  - PARITY: captures the parity bit → STOP.
  - STOP: on the fall event, the frame is good if data=1 and the 8 data bits plus the parity bit contain an odd number of ones. Good frame → accept. Otherwise → discard and pulse `frame_err`. Either way → IDLE.
- **Timeout:** in any non-IDLE state, a counter increments each cycle and clears on each fall event. Reaching `TIMEOUT_CYCLES` → IDLE, discard the frame, pulse `frame_err`. If a fall event and timeout coincide, the fall event wins.
- **Accept, code `E0`:** set `ext_pending`; `keyb_char` unchanged; no `new_key`.
- **Accept, code `F0`:** set `brk_pending`; `keyb_char` unchanged; no `new_key`.
- **Accept, any other code:** `keyb_char` <= {22'b0, `ext_pending`, `brk_pending`, code}; pulse `new_key`; clear both pending flags.
- **Pending flags after errors:** a discarded frame does not clear the pending flags.
- **Hold behaviour:** `keyb_char` holds its value indefinitely. Reads have no side effects; the block has no CPU-side handshake.

## Timing

- **Reset values:** `keyb_char`=0, `new_key`=0, `frame_err`=0, FSM=IDLE, `ps2_clk_filt`=1, synchronizers=1, pending flags=0, all counters=0.
- **Reset mid-frame:** everything returns to the reset values immediately; the partial frame is lost without a `frame_err` pulse.
- **Filter latency:** `ps2_clk_filt` falls 2 + `FILTER_LEN` cycles after a clean fall of `ps2_clk`.
- **Stop-bit timing:** `keyb_char` and `new_key` update in the cycle after the stop-bit fall event. `frame_err` from a bad stop or parity bit follows the same timing.
- **Timeout timing:** a timeout's `frame_err` pulses in the cycle the counter reaches `TIMEOUT_CYCLES`.
- **Pulse width:** `new_key` and `frame_err` are each high for exactly one cycle and never high together.

## Test plan

- **Make code:** frame 0x1C (parity 0, stop 1), PS/2 bit period 4000 cycles → `keyb_char`=0x0000001C, one `new_key` pulse, `frame_err` never asserted.
- **Break and extended prefixes:**
  - F0 (parity 1) then 1C → no pulse after F0; `keyb_char`=0x0000011C after 1C.
  - E0 75 → `keyb_char`=0x00000275.
  - E0 F0 75 → `keyb_char`=0x00000375; flags clear, so a following 1C gives 0x0000001C.
- **Parity error:** frame 0x1C with parity 1 → one `frame_err` pulse, `keyb_char` unchanged, no `new_key`. A following good 0x29 gives 0x00000029.
- **Glitch rejection:** `ps2_clk` low pulses of `FILTER_LEN`−1 cycles while idle and mid-frame → no state change. A subsequent frame 0x1C decodes correctly.
- **Timeout:** start bit plus 4 data bits, then silence → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last fall event, FSM in IDLE. A following frame 0x29 gives 0x00000029.
- **Reset:** assert `reset_n`=0 after 5 bits of a frame → all outputs 0 immediately. After release, frame 0x1C decodes to 0x0000001C with no `frame_err`.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver. Filters the PS/2 clock, decodes
//               11-bit device-to-host frames, folds E0/F0 prefixes into
//               flag bits and holds the last key code for CPU reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] keyb_char,
   output logic        new_key,
   output logic        frame_err
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FCW-1:0] C_FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TCW-1:0] C_TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     C_CODE_EXT  = 8'hE0;
   localparam logic [7:0]     C_CODE_BRK  = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   logic           clk_s1_q, clk_s2_q;
   logic           dat_s1_q, dat_s2_q;
   logic           filt_q, filt_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           w_fall;

   state_t         state_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           parity_q;
   logic [TCW-1:0] tmo_cnt_q;
   logic           ext_pend_q, brk_pend_q;
   logic [31:0]    keyb_char_q;
   logic           new_key_q, frame_err_q;

   // Two-flop synchronizers for the asynchronous PS/2 pins (idle level is 1)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Filter next state: toggle only after FILTER_LEN consecutive differing samples
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = filt_cnt_q;
      if (clk_s2_q == filt_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == C_FILT_LAST) begin
         filt_d     = clk_s2_q;
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + FCW'(1);
      end
   end

   // The FSM acts on the same edge the filtered clock falls
   assign w_fall = filt_q & ~filt_d;

   // Filtered clock and its run-length counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // Frame decoder, timeout, prefix folding and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tmo_cnt_q   <= '0;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         keyb_char_q <= '0;
         new_key_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         new_key_q   <= 1'b0;
         frame_err_q <= 1'b0;
         if (w_fall) begin
            // a fall event always wins over a coincident timeout
            tmo_cnt_q <= '0;
            case (state_q)
               S_IDLE: begin
                  if (!dat_s2_q) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               S_DATA: begin
                  shift_q   <= {dat_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  parity_q <= dat_s2_q;
                  state_q  <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (dat_s2_q && (^{shift_q, parity_q})) begin
                     if (shift_q == C_CODE_EXT) begin
                        ext_pend_q <= 1'b1;
                     end else if (shift_q == C_CODE_BRK) begin
                        brk_pend_q <= 1'b1;
                     end else begin
                        keyb_char_q <= {22'b0, ext_pend_q, brk_pend_q, shift_q};
                        new_key_q   <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end else if (state_q != S_IDLE) begin
            // error pulse is visible in the cycle the count reaches TIMEOUT_CYCLES
            if (tmo_cnt_q == C_TMO_LAST) begin
               state_q     <= S_IDLE;
               tmo_cnt_q   <= '0;
               frame_err_q <= 1'b1;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + TCW'(1);
            end
         end
      end
   end

   assign keyb_char = keyb_char_q;
   assign new_key   = new_key_q;
   assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Randomized scoreboard bench for ps2_keyboard_rx with a
//               frame-level reference model of the key/prefix rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

   localparam int F = 8;
   localparam int T = 5000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] keyb_char;
   logic        new_key;
   logic        frame_err;

   ps2_keyboard_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyb_char (keyb_char),
      .new_key   (new_key),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        is_err;
      logic [31:0] val;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   bit          m_ext = 1'b0;
   bit          m_brk = 1'b0;
   logic [31:0] m_char = 32'h0;
   int          last_fall = 0;
   int          tmo_exp_cyc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop one expectation per output pulse cycle
   always @(negedge clk) begin
      if (reset_n) begin
         if (new_key && frame_err) begin
            checks++;
            errors++;
            $display("FAIL pulse_overlap: new_key and frame_err both 1, required never together");
         end else if (new_key || frame_err) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: new_key=%0b frame_err=%0b keyb_char=0x%08h, required no pulse",
                        new_key, frame_err, keyb_char);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("pulse_kind_is_err", {31'b0, frame_err}, {31'b0, e.is_err});
               if (!e.is_err && new_key) chk("keyb_char_on_new_key", keyb_char, e.val);
            end
            if (frame_err && tmo_exp_cyc >= 0) begin
               chk("timeout_err_cycle", cyc, tmo_exp_cyc);
               tmo_exp_cyc = -1;
            end
         end
      end
   end

   task automatic bit_out(input logic b, input int half);
      ps2_data = b;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic do_glitch();
      repeat (F + 4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (F - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (F + 4) @(negedge clk);
   endtask

   task automatic push_exp(input logic is_err, input logic [31:0] val);
      exp_t e;
      e.is_err = is_err;
      e.val    = val;
      q.push_back(e);
   endtask

   task automatic drain(input string name, input int bound);
      for (int k = 0; k < bound && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d expected pulses missing, required 0", name, q.size());
         q.delete();
      end
   endtask

   // Reference model applied at frame level, then the frame is driven
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int half, input bit glitch);
      logic par;
      par = (~^code) ^ bad_par;
      if (bad_par || bad_stop) begin
         push_exp(1'b1, 32'h0);
      end else if (code == 8'hE0) begin
         m_ext = 1'b1;
      end else if (code == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         m_char = {22'b0, m_ext, m_brk, code};
         push_exp(1'b0, m_char);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      bit_out(1'b0, half);
      for (int i = 0; i < 8; i++) begin
         bit_out(code[i], half);
         if (glitch && i == 3) do_glitch();
      end
      bit_out(par, half);
      bit_out(~bad_stop, half);
      ps2_data = 1'b1;
      drain("frame_pulse_missing", 100);
      chk("keyb_char_hold", keyb_char, m_char);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [7:0] code;
      int         r;
      repeat (5) @(negedge clk);
      chk("reset_keyb_char", keyb_char, 32'h0);
      chk("reset_new_key", {31'b0, new_key}, 32'h0);
      chk("reset_frame_err", {31'b0, frame_err}, 32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      send_frame(8'h1C, 0, 0, 2000, 0);
      chk("make_code_1C", keyb_char, 32'h0000001C);

      send_frame(8'hF0, 0, 0, 30, 0);
      send_frame(8'h1C, 0, 0, 30, 0);
      chk("break_F0_1C", keyb_char, 32'h0000011C);

      send_frame(8'hE0, 0, 0, 30, 0);
      send_frame(8'h75, 0, 0, 30, 0);
      chk("ext_E0_75", keyb_char, 32'h00000275);

      send_frame(8'hE0, 0, 0, 30, 0);
      send_frame(8'hF0, 0, 0, 30, 0);
      send_frame(8'h75, 0, 0, 30, 0);
      chk("ext_brk_E0_F0_75", keyb_char, 32'h00000375);
      send_frame(8'h1C, 0, 0, 30, 0);
      chk("flags_cleared_1C", keyb_char, 32'h0000001C);

      send_frame(8'h1C, 1, 0, 30, 0);
      chk("parity_err_hold", keyb_char, 32'h0000001C);
      send_frame(8'h29, 0, 0, 30, 0);
      chk("after_parity_err_29", keyb_char, 32'h00000029);

      do_glitch();
      send_frame(8'h1C, 0, 0, 30, 1);
      chk("glitch_reject_1C", keyb_char, 32'h0000001C);

      // Timeout: start bit + 4 data bits, then silence
      code = 8'h5A;
      push_exp(1'b1, 32'h0);
      bit_out(1'b0, 30);
      for (int i = 0; i < 4; i++) bit_out(code[i], 30);
      ps2_data = 1'b1;
      tmo_exp_cyc = last_fall + 2 + F + T;
      drain("timeout_err_missing", T + 200);
      tmo_exp_cyc = -1;
      send_frame(8'h29, 0, 0, 30, 0);
      chk("after_timeout_29", keyb_char, 32'h00000029);

      // Randomized traffic
      for (int n = 0; n < 25; n++) begin
         r = int'($urandom_range(0, 7));
         if (r == 0)      code = 8'hE0;
         else if (r == 1) code = 8'hF0;
         else             code = 8'($urandom);
         r = int'($urandom_range(0, 9));
         send_frame(code, r == 0, r == 1, int'($urandom_range(12, 40)), 0);
      end

      // Reset mid-frame
      send_frame(8'hE0, 0, 0, 30, 0);
      code = 8'h33;
      bit_out(1'b0, 30);
      for (int i = 0; i < 4; i++) bit_out(code[i], 30);
      reset_n = 1'b0;
      #1;
      chk("midreset_keyb_char", keyb_char, 32'h0);
      chk("midreset_new_key", {31'b0, new_key}, 32'h0);
      chk("midreset_frame_err", {31'b0, frame_err}, 32'h0);
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_char = 32'h0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (F + 5) @(negedge clk);
      send_frame(8'h1C, 0, 0, 30, 0);
      chk("after_reset_1C", keyb_char, 32'h0000001C);

      chk("scoreboard_empty", q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
